// File: rtl/inst_fetch_stage.sv
// ============================================================================
// Module   : inst_fetch_stage
// Purpose  : Instruction-fetch stage of the 16-bit pipelined CPU. Owns the
//            PC, runs a req/ack handshake with instruction memory, holds the
//            fetched word while decode stalls and drives IR/NPC_OUT to decode.
//            Taken branches from EXE/MEM redirect the PC and flush IR.
// Options  : `define INST_FETCH_COUNT_EN to add the FETCH_CNT issue counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd1,
  parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [15:0] BR_TARGET,
  output logic        IMEM_REQ,
  output logic [15:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IR,
  output logic [15:0] NPC_OUT,
  output logic        IR_VALID,
  output logic [2:0]  ESTADO
`ifdef INST_FETCH_COUNT_EN
  ,
  output logic [15:0] FETCH_CNT
`endif
);

  // FSM encodings; 5..7 are unused and recover to S_RESET
  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]  state;
  logic [15:0] pc;
  logic [31:0] buffer;
  logic [15:0] pc_next_seq;
  logic        in_fetch;
  logic        in_issue;
  logic        flush;
  logic        issue;

  // Decode the current state into the qualifiers shared by the registers
  always_comb begin
    pc_next_seq = pc + PC_INC;
    in_fetch    = (state == S_REQ) || (state == S_WAIT);
    in_issue    = (state == S_ISSUE) || (state == S_HOLD);
    // A branch only acts in a live (non-reset, legal) state and beats everything else
    flush       = BR_TAKEN && (in_fetch || in_issue);
    issue       = in_issue && !STALL && !BR_TAKEN;
  end

  assign IMEM_REQ  = in_fetch;
  assign IMEM_ADDR = pc;
  assign ESTADO    = state;

  // State machine, PC and the fetch buffer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_RESET;
      pc     <= RESET_PC;
      buffer <= NOP_IR;
    end else if (flush) begin
      // Redirect; any word acknowledged this cycle is dropped
      state  <= S_REQ;
      pc     <= BR_TARGET;
      buffer <= NOP_IR;
    end else begin
      case (state)
        S_RESET: state <= S_REQ;
        S_REQ, S_WAIT: begin
          if (IMEM_ACK) begin
            buffer <= IMEM_DATA;
            state  <= S_ISSUE;
          end else begin
            state  <= S_WAIT;
          end
        end
        S_ISSUE, S_HOLD: begin
          if (issue) begin
            pc    <= pc_next_seq;
            state <= S_REQ;
          end else begin
            state <= S_HOLD;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

  // IF/ID pipeline register: IR/NPC_OUT load on issue, IR clears on flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      IR       <= NOP_IR;
      NPC_OUT  <= RESET_PC;
      IR_VALID <= 1'b0;
    end else begin
      IR_VALID <= 1'b0;
      if (flush) begin
        IR <= NOP_IR;
      end else if (issue) begin
        IR       <= buffer;
        NPC_OUT  <= pc_next_seq;
        IR_VALID <= 1'b1;
      end
    end
  end

`ifdef INST_FETCH_COUNT_EN
  logic [15:0] fetch_cnt;

  // Saturating count of issued instructions; flushes never issue
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_cnt <= 16'h0000;
    end else if (issue && (fetch_cnt != 16'hFFFF)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  assign FETCH_CNT = fetch_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_stage.sv
// ============================================================================
// Module   : tb_inst_fetch_stage
// Purpose  : Self-checking bench for inst_fetch_stage. Directed stimulus
//            pushes expected IR/NPC pairs into a scoreboard queue; a monitor
//            pops and compares on every IR_VALID pulse. A second instance
//            with RESET_PC=16'hFFFF covers PC wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_stage;

  typedef struct {
    logic [31:0] ir;
    logic [15:0] npc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL;
  logic        BR_TAKEN;
  logic [15:0] BR_TARGET;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_DATA;
  logic [31:0] IR;
  logic [15:0] NPC_OUT;
  logic        IR_VALID;
  logic [2:0]  ESTADO;

  // second instance: zero-wait memory tied straight back to its request
  logic        br2;
  logic        req2;
  logic [15:0] addr2;
  logic        ack2;
  logic [31:0] data2;
  logic [31:0] ir2;
  logic [15:0] npc2;
  logic        valid2;
  logic [2:0]  estado2;

`ifdef INST_FETCH_COUNT_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  bit   mem_en    = 1'b0;
  int   ack_delay = 0;
  int   waited    = 0;

  always #5 CLK = ~CLK;

  assign ack2  = req2;
  assign data2 = {16'h1234, addr2};

  inst_fetch_stage u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .STALL     (STALL),
    .BR_TAKEN  (BR_TAKEN),
    .BR_TARGET (BR_TARGET),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_DATA (IMEM_DATA),
    .IR        (IR),
    .NPC_OUT   (NPC_OUT),
    .IR_VALID  (IR_VALID),
    .ESTADO    (ESTADO)
`ifdef INST_FETCH_COUNT_EN
    ,
    .FETCH_CNT (cnt1)
`endif
  );

  inst_fetch_stage #(.RESET_PC(16'hFFFF)) u_dut2 (
    .CLK       (CLK),
    .RST       (RST),
    .STALL     (1'b0),
    .BR_TAKEN  (br2),
    .BR_TARGET (16'h0100),
    .IMEM_REQ  (req2),
    .IMEM_ADDR (addr2),
    .IMEM_ACK  (ack2),
    .IMEM_DATA (data2),
    .IR        (ir2),
    .NPC_OUT   (npc2),
    .IR_VALID  (valid2),
    .ESTADO    (estado2)
`ifdef INST_FETCH_COUNT_EN
    ,
    .FETCH_CNT (cnt2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected issues still pending", sb.size());
    end
  endtask

  function automatic logic [31:0] memword(input logic [15:0] a);
    return 32'h0B6A_0000 + {16'h0000, a};
  endfunction

  // Instruction memory: acknowledges after ack_delay idle request cycles
  always @(negedge CLK) begin
    if (mem_en && IMEM_REQ) begin
      if (waited >= ack_delay) begin
        IMEM_ACK  = 1'b1;
        IMEM_DATA = memword(IMEM_ADDR);
        waited    = 0;
      end else begin
        IMEM_ACK  = 1'b0;
        IMEM_DATA = 32'hDEAD_BEEF;
        waited++;
      end
    end else begin
      IMEM_ACK  = 1'b0;
      IMEM_DATA = 32'hDEAD_BEEF;
      waited    = 0;
    end
  end

  // Scoreboard monitor: every issue must match the oldest expectation
  always @(negedge CLK) begin
    if (IR_VALID === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got IR=%0h NPC=%0h expected no issue", IR, NPC_OUT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ir", IR, e.ir);
        chk("sb_npc", {16'h0, NPC_OUT}, {16'h0, e.npc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 16'h0000; br2 = 1'b0;
    IMEM_ACK = 1'b0; IMEM_DATA = 32'hDEAD_BEEF;

    // 1: reset values, then idle fetch without ACK
    step(1);
    chk("rst_ir", IR, 32'h0);
    chk("rst_npc", {16'h0, NPC_OUT}, 32'h0);
    chk("rst_valid", {31'h0, IR_VALID}, 32'h0);
    chk("rst_req", {31'h0, IMEM_REQ}, 32'h0);
    chk("rst_estado", {29'h0, ESTADO}, 32'd0);
    step(1);
    chk("rst_estado2", {29'h0, ESTADO}, 32'd0);
    RST = 1'b0;
    step(1);
    chk("t1_estado_req", {29'h0, ESTADO}, 32'd1);
    chk("t1_req", {31'h0, IMEM_REQ}, 32'h1);
    step(1);
    chk("t1_estado_wait", {29'h0, ESTADO}, 32'd2);
    step(1);
    chk("t1_estado_wait2", {29'h0, ESTADO}, 32'd2);
    chk("t1_addr", {16'h0, IMEM_ADDR}, 32'h0);

    // 2: zero-wait memory, first issue 3 cycles after release, then every 2
    mem_en = 1'b1; ack_delay = 0;
    sb.push_back('{32'h0B6A0000, 16'd1});
    sb.push_back('{32'h0B6A0001, 16'd2});
    sb.push_back('{32'h0B6A0002, 16'd3});
    do_reset();
    step(1);
    chk("t2_e1_valid", {31'h0, IR_VALID}, 32'h0);
    step(1);
    chk("t2_e2_valid", {31'h0, IR_VALID}, 32'h0);
    chk("t2_e2_estado", {29'h0, ESTADO}, 32'd3);
    step(1);
    chk("t2_e3_valid", {31'h0, IR_VALID}, 32'h1);
    chk("t2_e3_addr", {16'h0, IMEM_ADDR}, 32'h1);
    step(1);
    chk("t2_e4_valid", {31'h0, IR_VALID}, 32'h0);
    step(1);
    chk("t2_e5_valid", {31'h0, IR_VALID}, 32'h1);
    step(1);
    mem_en = 1'b0;
    step(1);
    chk("t2_e7_valid", {31'h0, IR_VALID}, 32'h1);
    wait_drain(4);

    // 3: ACK delayed 3 cycles
    mem_en = 1'b1; ack_delay = 3;
    sb.push_back('{32'h0B6A0000, 16'd1});
    do_reset();
    step(1);
    chk("t3_estado_req", {29'h0, ESTADO}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t3_estado_wait", {29'h0, ESTADO}, 32'd2);
      chk("t3_req", {31'h0, IMEM_REQ}, 32'h1);
      chk("t3_addr", {16'h0, IMEM_ADDR}, 32'h0);
      chk("t3_ir_hold", IR, 32'h0);
    end
    step(1);
    chk("t3_estado_issue", {29'h0, ESTADO}, 32'd3);
    chk("t3_ir_before", IR, 32'h0);
    ack_delay = 0;
    step(1);
    chk("t3_valid", {31'h0, IR_VALID}, 32'h1);

    // 4: stall for 4 cycles in S_ISSUE
    step(1);
    chk("t4_estado_issue", {29'h0, ESTADO}, 32'd3);
    STALL = 1'b1;
    sb.push_back('{32'h0B6A0001, 16'd2});
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t4_estado_hold", {29'h0, ESTADO}, 32'd4);
      chk("t4_no_valid", {31'h0, IR_VALID}, 32'h0);
      chk("t4_ir_stable", IR, 32'h0B6A0000);
    end
    STALL = 1'b0;
    ack_delay = 2;
    step(1);
    chk("t4_valid", {31'h0, IR_VALID}, 32'h1);
    chk("t4_pc_adv", {16'h0, IMEM_ADDR}, 32'h2);

    // 5: branch coincident with ACK in S_WAIT
    step(2);
    chk("t5_ack_in_wait", {28'h0, ESTADO, IMEM_ACK}, {28'h0, 3'd2, 1'b1});
    BR_TAKEN = 1'b1; BR_TARGET = 16'd500;
    step(1);
    BR_TAKEN = 1'b0;
    chk("t5_ir_nop", IR, 32'h0);
    chk("t5_valid", {31'h0, IR_VALID}, 32'h0);
    chk("t5_addr", {16'h0, IMEM_ADDR}, 32'd500);
    chk("t5_estado", {29'h0, ESTADO}, 32'd1);
    sb.push_back('{32'h0B6A01F4, 16'd501});
    wait_drain(20);

    // branch to the top of memory: NPC wraps to zero
    BR_TAKEN = 1'b1; BR_TARGET = 16'hFFFF;
    step(1);
    BR_TAKEN = 1'b0;
    chk("wrap_addr", {16'h0, IMEM_ADDR}, 32'h0000FFFF);
    sb.push_back('{32'h0B6AFFFF, 16'h0000});
    wait_drain(20);
    chk("wrap_pc", {16'h0, IMEM_ADDR}, 32'h0);

    // 6: RESET_PC=16'hFFFF instance
    mem_en = 1'b0;
    do_reset();
    step(1);
    chk("t6_addr_first", {16'h0, addr2}, 32'h0000FFFF);
    chk("t6_req", {31'h0, req2}, 32'h1);
    step(2);
    chk("t6_valid1", {31'h0, valid2}, 32'h1);
    chk("t6_npc1", {16'h0, npc2}, 32'h0);
    chk("t6_ir1", ir2, 32'h1234FFFF);
    chk("t6_addr_second", {16'h0, addr2}, 32'h0);
    step(2);
    chk("t6_valid2", {31'h0, valid2}, 32'h1);
    chk("t6_npc2", {16'h0, npc2}, 32'h1);
    chk("t6_ir2", ir2, 32'h12340000);
`ifdef INST_FETCH_COUNT_EN
    chk("t6_cnt_two", {16'h0, cnt2}, 32'd2);
`endif
    br2 = 1'b1;
    step(1);
    br2 = 1'b0;
    chk("t6_flush_valid", {31'h0, valid2}, 32'h0);
    chk("t6_flush_ir", ir2, 32'h0);
    chk("t6_flush_addr", {16'h0, addr2}, 32'h0100);
`ifdef INST_FETCH_COUNT_EN
    chk("t6_cnt_flush", {16'h0, cnt2}, 32'd2);
`endif
    step(1);
    wait_drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
